act_unit_vec: RTL and testbench
===============================

# act_unit_vec

Parametrised, multi-lane FP32 activation unit with a valid/ready handshake and a runtime-selectable mode: identity, ReLU, leaky ReLU with a power-of-two slope, or clipped ReLU. It evaluates all activations natively on IEEE-754 bit fields, so no floating-point IP is needed. It sits between the MLP accumulator output and the next layer's input buffer. It also keeps a saturating count of zero outputs, used for activation-sparsity statistics.

## Interface
- LANES, 4, number of independent FP32 lanes per beat (1..16)
- LEAK_SHIFT, 3, leaky slope is 2^-LEAK_SHIFT (1..8)
- CLIP_VAL, 32'h40C00000, clip ceiling for mode 3 (6.0); must be positive, finite and normal
- CNT_W, 32, width of zero counter
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  2  0 identity, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU; sampled with each accepted beat
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat
- z  in  LANES*32  input vector; lane i is z[32*i+31:32*i]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- a  out  LANES*32  activation vector, same lane packing as z
- cnt_clr  in  1  synchronous clear of zero_cnt
- zero_cnt  out  CNT_W  saturating count of output lanes equal to 32'h00000000

## Operation
- Two-stage pipeline:
  - S1 registers z, mode and per-lane class flags: sign, exponent==0 (zero or denormal), exponent==255 with mantissa!=0 (NaN), and the result of comparing magnitude bits against CLIP_VAL.
  - S2 computes and registers a.
- Per-lane rules, modes 1-3 (mode 0 passes the raw bits unchanged, NaN included):
  - NaN, any sign -> 32'h7FC00000.
  - Exponent==0 (±0 or denormal, any sign) -> 32'h00000000. Denormals are flushed.
  - Positive normal or +inf -> x in modes 1 and 2. In mode 3 -> min(x, CLIP_VAL), compared as unsigned bits[30:0]; +inf -> CLIP_VAL.
  - Negative normal or -inf -> 32'h00000000 in modes 1 and 3.
  - Negative normal or -inf in mode 2:
    - -inf stays -inf (32'hFF800000).
    - If exponent > LEAK_SHIFT: sign kept, exponent -= LEAK_SHIFT, mantissa kept.
    - Otherwise: 32'h00000000 (underflow flush).
- Zero counter:
  - On each output transfer (out_valid && out_ready), add the number of lanes with a == 32'h00000000.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr has priority: when it is high, zero_cnt becomes 0 next cycle and any increment in that cycle is discarded.
- Reset: all pipeline valids, data registers, a, out_valid and zero_cnt go to 0. in_ready is 1 after reset.
- Reset asserted mid-operation discards in-flight beats. No partial output appears after deassert.

## Timing
- Handshake:
  - Input transfers on in_valid && in_ready.
  - Output transfers on out_valid && out_ready.
  - in_ready = !(out_valid && !out_ready): a global stall.
- Latency: an accepted beat appears on a/out_valid 2 cycles later if not stalled.
- Throughput: 1 beat/cycle with out_ready held high.
- Stall: while out_valid && !out_ready, both stages hold. a, out_valid and the S1 contents stay stable, and no input is accepted.
- Bubbles: the pipeline advances when not stalled, so an S2 bubble is filled even if S1 is empty.
- A mode change between beats takes effect per beat; the pipeline is not flushed.
- Simultaneous input accept and output transfer in one cycle are both legal.
- zero_cnt updates the cycle after the transfer, i.e. it is registered.

## Test plan
- Reset then ReLU: LANES=4, mode=1, z lanes = {32'hBF800000 (-1.0), 32'h3F800000 (1.0), 32'h80000000 (-0), 32'h00000001 (denormal)}, out_ready=1.
  - Required: 2 cycles later a={0, 32'h3F800000, 0, 0}, out_valid=1, then zero_cnt=3.
- Leaky, LEAK_SHIFT=3, mode=2:
  - -8.0 (32'hC1000000) -> 32'hBF800000 (-1.0).
  - 32'h81800000 (exponent 3) -> 0.
  - -inf -> 32'hFF800000.
  - 2.5 -> 2.5.
- Clip, mode=3:
  - 7.0 (32'h40E00000) -> 32'h40C00000.
  - 5.0 -> 5.0.
  - +inf -> 32'h40C00000.
  - -3.0 -> 0.
  - NaN 32'hFFC00001 -> 32'h7FC00000.
  - Same NaN in mode 0 -> 32'hFFC00001 unchanged.
- Backpressure: stream 6 beats with out_ready toggling 1,0,0,1,...
  - Outputs are in order, none lost or duplicated.
  - a is stable while stalled; in_ready=0 exactly when out_valid && !out_ready.
- Counter: preload zero_cnt near saturation (CNT_W=4, send all-negative beats in ReLU).
  - Count sticks at 15.
  - Asserting cnt_clr during a transfer of 4 zero lanes yields 0, not 4.
- Reset mid-stream: assert rst with 2 beats in flight.
  - out_valid=0, a=0 and zero_cnt=0 immediately (asynchronous).
  - After deassert, no stale beat appears.

Source files
------------

// File: rtl/act_unit_vec.sv
// Multi-lane FP32 activation unit (identity / ReLU / leaky ReLU / clipped ReLU).
// Two-stage valid/ready pipeline with a saturating zero-output counter.
module act_unit_vec #(
    parameter int          LANES      = 4,
    parameter int          LEAK_SHIFT = 3,
    parameter logic [31:0] CLIP_VAL   = 32'h40C00000,
    parameter int          CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*32-1:0]   a,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      zero_cnt
);

    localparam int          ZW       = $clog2(LANES + 1);
    localparam logic [7:0]  LEAK_E   = 8'(LEAK_SHIFT);
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [31:0] NEG_INF  = 32'hFF800000;
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic                 s1_valid_q;
    logic [LANES*32-1:0]  s1_z_q;
    logic [1:0]           s1_mode_q;
    logic [LANES-1:0]     s1_sign_q, s1_zexp_q, s1_nan_q, s1_gt_q;
    logic [LANES-1:0]     sign_d, zexp_d, nan_d, gt_d;

    logic                 out_valid_q;
    logic [LANES*32-1:0]  a_q, a_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ZW-1:0]        zeros_s;
    logic [CNT_W:0]       cnt_sum_s;
    logic                 stall_s, xfer_s;

    // Per-lane activation from the S1 class flags; mode 0 is a raw pass-through.
    function automatic logic [31:0] act_lane(
        input logic [1:0]  m,
        input logic [31:0] x,
        input logic        sgn,
        input logic        zexp,
        input logic        nan,
        input logic        gt
    );
        logic [31:0] r;
        logic [7:0]  e;
        e = x[30:23];
        case (m)
            2'd0: r = x;
            2'd1, 2'd2, 2'd3: begin
                if (nan) begin
                    r = QNAN;
                end else if (zexp) begin
                    r = 32'h00000000;
                end else if (!sgn) begin
                    r = (m == 2'd3 && gt) ? CLIP_VAL : x;
                end else if (m != 2'd2) begin
                    r = 32'h00000000;
                end else if (e == 8'hFF) begin
                    r = NEG_INF;
                end else if (e > LEAK_E) begin
                    r = {1'b1, e - LEAK_E, x[22:0]};
                end else begin
                    r = 32'h00000000;
                end
            end
            default: r = x;
        endcase
        return r;
    endfunction

    assign stall_s   = out_valid_q && !out_ready;
    assign xfer_s    = out_valid_q && out_ready;
    assign in_ready  = !stall_s;
    assign out_valid = out_valid_q;
    assign a         = a_q;
    assign zero_cnt  = cnt_q;

    // Classify incoming lanes so S2 only has to select a result.
    always_comb begin
        sign_d = '0;
        zexp_d = '0;
        nan_d  = '0;
        gt_d   = '0;
        for (int i = 0; i < LANES; i++) begin
            sign_d[i] = z[32*i+31];
            zexp_d[i] = (z[32*i+23 +: 8] == 8'h00);
            nan_d[i]  = (z[32*i+23 +: 8] == 8'hFF) && (z[32*i +: 23] != 23'h000000);
            gt_d[i]   = (z[32*i +: 31] > CLIP_VAL[30:0]);
        end
    end

    // S2 result for every lane.
    always_comb begin
        a_d = '0;
        for (int i = 0; i < LANES; i++) begin
            a_d[32*i +: 32] = act_lane(s1_mode_q, s1_z_q[32*i +: 32], s1_sign_q[i],
                                       s1_zexp_q[i], s1_nan_q[i], s1_gt_q[i]);
        end
    end

    // Zero-lane tally of the beat currently presented, and the saturating next count.
    always_comb begin
        zeros_s = '0;
        for (int i = 0; i < LANES; i++) begin
            zeros_s = zeros_s + ZW'(a_q[32*i +: 32] == 32'h00000000);
        end
        cnt_sum_s = {1'b0, cnt_q} + (CNT_W+1)'(zeros_s);
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (xfer_s) begin
            cnt_d = (cnt_sum_s > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum_s[CNT_W-1:0];
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline registers: both stages hold together while the output is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_z_q      <= '0;
            s1_mode_q   <= 2'd0;
            s1_sign_q   <= '0;
            s1_zexp_q   <= '0;
            s1_nan_q    <= '0;
            s1_gt_q     <= '0;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            cnt_q       <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (!stall_s) begin
                s1_valid_q  <= in_valid;
                out_valid_q <= s1_valid_q;
                if (in_valid) begin
                    s1_z_q    <= z;
                    s1_mode_q <= mode;
                    s1_sign_q <= sign_d;
                    s1_zexp_q <= zexp_d;
                    s1_nan_q  <= nan_d;
                    s1_gt_q   <= gt_d;
                end
                if (s1_valid_q) begin
                    a_q <= a_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_act_unit_vec.sv
// Self-checking bench for act_unit_vec: directed literal beats, randomized
// traffic with backpressure against a behavioural model, counter and reset cases.
module tb_act_unit_vec;

    localparam int          LANES = 4;
    localparam int          LEAK  = 3;
    localparam int          CNT_W = 4;
    localparam logic [31:0] CLIP  = 32'h40C00000;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          mode;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*32-1:0] z;
    logic                out_valid;
    logic                out_ready;
    logic [LANES*32-1:0] a;
    logic                cnt_clr;
    logic [CNT_W-1:0]    zero_cnt;

    act_unit_vec #(.LANES(LANES), .LEAK_SHIFT(LEAK), .CLIP_VAL(CLIP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .z(z), .out_valid(out_valid), .out_ready(out_ready), .a(a),
        .cnt_clr(cnt_clr), .zero_cnt(zero_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [127:0] exp_q[$];
    int cnt_m = 0;
    logic prev_stall = 1'b0;
    logic [127:0] prev_a;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Activation from the value's meaning: NaN / zero-or-denormal / positive / negative.
    function automatic logic [31:0] ref_act(input int m, input logic [31:0] x);
        int  e;
        bit  neg;
        e   = int'(x[30:23]);
        neg = x[31];
        if (m == 0) return x;
        if (e == 255 && x[22:0] != 0) return 32'h7FC00000;
        if (e == 0) return 32'h0;
        if (!neg) begin
            if (m == 3 && x[30:0] > CLIP[30:0]) return CLIP;
            return x;
        end
        if (m != 2) return 32'h0;
        if (e == 255) return 32'hFF800000;
        if (e - LEAK >= 1) return {1'b1, 8'(e - LEAK), x[22:0]};
        return 32'h0;
    endfunction

    function automatic logic [127:0] ref_vec(input int m, input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < LANES; i++) r[32*i +: 32] = ref_act(m, v[32*i +: 32]);
        return r;
    endfunction

    function automatic logic [31:0] rand_lane();
        logic        s;
        logic [22:0] f;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case ($urandom_range(0, 7))
            0: return {s, 8'($urandom_range(0, 10)), f};
            1: return {s, 8'h00, f};
            2: return {s, 8'hFF, 23'h0};
            3: return {s, 8'hFF, f | 23'h1};
            4: return {s, CLIP[30:0] + 31'($urandom_range(0, 4)) - 31'd2};
            5: return {s, 31'h0};
            default: return 32'($urandom);
        endcase
    endfunction

    // Scoreboard: compare every presented output, counter and handshake each cycle.
    always @(negedge clk) begin
        int zeros;
        if (rst) begin
            zeros = 0;
            check("in_ready", in_ready, !(out_valid && !out_ready));
            check("zero_cnt_model", zero_cnt, cnt_m);
            if (prev_stall) begin
                check("stall_hold_valid", out_valid, 1'b1);
                check("stall_hold_a", a, prev_a);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got beat %h expected none", a);
                end else begin
                    check("a_model", a, exp_q[0]);
                    if (out_ready) begin
                        for (int i = 0; i < LANES; i++)
                            if (exp_q[0][32*i +: 32] == 32'h0) zeros++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (cnt_clr) cnt_m = 0;
            else if (out_valid && out_ready) cnt_m = (cnt_m + zeros > 15) ? 15 : cnt_m + zeros;
            prev_stall = out_valid && !out_ready;
            prev_a     = a;
            if (in_valid && in_ready) exp_q.push_back(ref_vec(int'(mode), z));
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_directed(input string name, input int m, input logic [127:0] v,
                                 input logic [127:0] exp);
        int lat;
        mode = 2'(m); z = v; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, 2);
        check(name, a, exp);
    endtask

    initial begin
        rst = 1'b0; mode = 2'd0; in_valid = 1'b0; z = '0; out_ready = 1'b1; cnt_clr = 1'b0;

        check("model_leaky", ref_act(2, 32'hC1000000), 32'hBF800000);
        check("model_clip", ref_act(3, 32'h40E00000), 32'h40C00000);

        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_a", a, 128'h0);
        check("rst_zero_cnt", zero_cnt, 4'd0);
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;

        send_directed("relu", 1, {32'h00000001, 32'h80000000, 32'h3F800000, 32'hBF800000},
                      {32'h0, 32'h0, 32'h3F800000, 32'h0});
        @(posedge clk); #1;
        check("relu_zero_cnt", zero_cnt, 4'd3);
        send_directed("leaky", 2, {32'h40200000, 32'hFF800000, 32'h81800000, 32'hC1000000},
                      {32'h40200000, 32'hFF800000, 32'h0, 32'hBF800000});
        send_directed("clip", 3, {32'hC0400000, 32'h7F800000, 32'h40A00000, 32'h40E00000},
                      {32'h0, 32'h40C00000, 32'h40A00000, 32'h40C00000});
        send_directed("nan_m3", 3, {32'hFF800000, 32'h00000000, 32'h3F800000, 32'hFFC00001},
                      {32'h0, 32'h0, 32'h3F800000, 32'h7FC00000});
        send_directed("nan_m0", 0, {32'hFF800000, 32'h00000000, 32'h3F800000, 32'hFFC00001},
                      {32'hFF800000, 32'h00000000, 32'h3F800000, 32'hFFC00001});

        for (int k = 0; k < 5; k++)
            send_directed("neg_relu", 1, {4{32'hBF800000}}, 128'h0);
        @(posedge clk); #1;
        check("cnt_saturated", zero_cnt, 4'd15);

        mode = 2'd1; z = {4{32'hC0000000}}; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        check("clr_beat_present", out_valid, 1'b1);
        cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        check("cnt_clr_priority", zero_cnt, 4'd0);

        for (int cyc = 0; cyc < 300; cyc++) begin
            mode = 2'($urandom_range(0, 3));
            for (int i = 0; i < LANES; i++) z[32*i +: 32] = rand_lane();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (cyc < 12) ? (cyc % 3 == 0) : ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("drain_empty", exp_q.size(), 0);

        mode = 2'd1; z = {4{32'h3F800000}}; in_valid = 1'b1;
        @(posedge clk); #1 z = {4{32'h40000000}};
        @(posedge clk); #1 in_valid = 1'b0;
        #2 rst = 1'b0;
        exp_q.delete();
        cnt_m = 0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_a", a, 128'h0);
        check("midrst_zero_cnt", zero_cnt, 4'd0);
        @(posedge clk); #3 rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("post_rst_no_stale", out_valid, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
